// File: rtl/fromrecfn_pipe_pkg.sv
// Shared constants and class encoding for the recoded-to-IEEE binary32 converter.
package fromrecfn_pipe_pkg;

    localparam int FP_BITS     = 32;
    localparam int EXP_BITS    = 8;
    localparam int FRA_BITS    = 23;
    localparam int EXPREC_BITS = 9;
    localparam int SIG_BITS    = 24;
    localparam int EXP_OFFSET  = 129;

    // Top three recoded exponent bits that mark the special classes
    localparam logic [2:0] REC_ZERO = 3'b000;
    localparam logic [2:0] REC_INF  = 3'b110;
    localparam logic [2:0] REC_NAN  = 3'b111;

    // Recoded exponents in [SUB_LO, SUB_HI) are IEEE subnormals
    localparam logic [EXPREC_BITS-1:0] SUB_LO = 9'd107;
    localparam logic [EXPREC_BITS-1:0] SUB_HI = 9'd130;

    localparam logic [FP_BITS-1:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        CLS_ZERO      = 3'd0,
        CLS_INF       = 3'd1,
        CLS_NAN       = 3'd2,
        CLS_NORMAL    = 3'd3,
        CLS_SUBNORMAL = 3'd4,
        CLS_BAD       = 3'd5
    } rec_class_e;

endpackage

// File: rtl/fromrecfn_pipe_shift.sv
// Right barrel shifter that denormalises the significand; returns the fraction field.
module rec_denorm_shift
    import fromrecfn_pipe_pkg::*;
#(
    parameter int SIG_W = SIG_BITS,
    parameter int FRA_W = FRA_BITS
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [4:0]       amt,
    output logic [FRA_W-1:0] frac
);

    // Shifted-out bits are dropped; no rounding happens here
    assign frac = FRA_W'(sig >> amt);

endmodule

// File: rtl/fromrecfn_pipe.sv
// Two-stage recoded float -> IEEE binary32 converter with valid/ready on both sides.
// Stage 1 classifies the recoded exponent, stage 2 shifts and packs the result.
module fromrecfn_pipe
    import fromrecfn_pipe_pkg::*;
#(
    parameter int FP_BITS_P     = FP_BITS,
    parameter int EXP_BITS_P    = EXP_BITS,
    parameter int FRA_BITS_P    = FRA_BITS,
    parameter int EXPREC_BITS_P = EXPREC_BITS,
    parameter int SIG_BITS_P    = SIG_BITS,
    parameter int EXP_OFFSET_P  = EXP_OFFSET
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXPREC_BITS_P-1:0] in_exp,
    input  logic [SIG_BITS_P-1:0]    in_sig,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FP_BITS_P-1:0]     out_fp,
    output logic                     out_bad_enc
);

    // Stage 1 registers
    logic                    s1_valid;
    rec_class_e              s1_cls;
    logic                    s1_sign;
    logic [SIG_BITS_P-1:0]   s1_sig;
    logic [EXP_BITS_P-1:0]   s1_amt;   // IEEE exponent (normal) or shift (subnormal)

    rec_class_e              cls_d;
    logic [EXP_BITS_P-1:0]   amt_d;
    logic [FP_BITS_P-1:0]    fp_d;
    logic                    bad_d;
    logic [FRA_BITS_P-1:0]   sub_frac;
    logic [FRA_BITS_P-1:0]   nan_frac;
    logic                    s2_advance;
    logic                    in_fire;

    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !rst && (!s1_valid || s2_advance);
    assign in_fire    = in_valid && in_ready;

    // Classify the incoming recoded exponent and precompute exponent / shift
    always_comb begin
        cls_d = CLS_BAD;
        amt_d = '0;
        if (in_exp[EXPREC_BITS_P-1 -: 3] == REC_ZERO) begin
            cls_d = CLS_ZERO;
        end else if (in_exp[EXPREC_BITS_P-1 -: 3] == REC_INF) begin
            cls_d = CLS_INF;
        end else if (in_exp[EXPREC_BITS_P-1 -: 3] == REC_NAN) begin
            cls_d = CLS_NAN;
        end else if (in_exp >= SUB_HI) begin
            cls_d = CLS_NORMAL;
            amt_d = EXP_BITS_P'(in_exp - EXPREC_BITS_P'(EXP_OFFSET_P));
        end else if (in_exp >= SUB_LO) begin
            cls_d = CLS_SUBNORMAL;
            amt_d = EXP_BITS_P'(SUB_HI - in_exp);
        end
    end

    // Stage 1 capture; valid bit follows the input whenever the stage may move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cls   <= CLS_ZERO;
            s1_sign  <= 1'b0;
            s1_sig   <= '0;
            s1_amt   <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_fire) begin
                s1_cls  <= cls_d;
                s1_sign <= in_sign;
                s1_sig  <= in_sig;
                s1_amt  <= amt_d;
            end
        end
    end

    rec_denorm_shift #(
        .SIG_W (SIG_BITS_P),
        .FRA_W (FRA_BITS_P)
    ) u_shift (
        .sig  (s1_sig),
        .amt  (s1_amt[4:0]),
        .frac (sub_frac)
    );

    // A NaN with an all-zero payload would read back as infinity; force the quiet bit
    assign nan_frac = (s1_sig[FRA_BITS_P-1:0] == '0)
                    ? {1'b1, {(FRA_BITS_P-1){1'b0}}}
                    : s1_sig[FRA_BITS_P-1:0];

    // Pack the IEEE word for the class held in stage 1
    always_comb begin
        fp_d  = CANON_NAN;
        bad_d = 1'b0;
        case (s1_cls)
            CLS_ZERO:      fp_d = {s1_sign, {(FP_BITS_P-1){1'b0}}};
            CLS_INF:       fp_d = {s1_sign, {EXP_BITS_P{1'b1}}, {FRA_BITS_P{1'b0}}};
            CLS_NAN:       fp_d = {s1_sign, {EXP_BITS_P{1'b1}}, nan_frac};
            CLS_NORMAL:    fp_d = {s1_sign, s1_amt, s1_sig[FRA_BITS_P-1:0]};
            CLS_SUBNORMAL: fp_d = {s1_sign, {EXP_BITS_P{1'b0}}, sub_frac};
            default: begin
                fp_d  = CANON_NAN;
                bad_d = 1'b1;
            end
        endcase
    end

    // Stage 2 output register; holds while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_fp      <= '0;
            out_bad_enc <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_fp      <= fp_d;
                out_bad_enc <= bad_d;
            end
        end
    end

endmodule

// File: tb/tb_fromrecfn_pipe.sv
// Directed bench for fromrecfn_pipe with an expected-result queue.
module tb_fromrecfn_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [8:0]  in_exp = '0;
    logic [23:0] in_sig = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_fp;
    logic        out_bad_enc;

    typedef struct {
        logic [31:0] fp;
        logic        bad;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_fp = '0;
    logic        prev_bad = 1'b0;

    fromrecfn_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_sig      (in_sig),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_fp      (out_fp),
        .out_bad_enc (out_bad_enc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Output side: pop and compare on each transfer, and watch stability while stalled
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                check("stall_fp_stable", out_fp, prev_fp);
                check("stall_bad_stable", {31'b0, out_bad_enc}, {31'b0, prev_bad});
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_output", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("out_fp", out_fp, e.fp);
                    check("out_bad_enc", {31'b0, out_bad_enc}, {31'b0, e.bad});
                    if (e.lat) check("latency", 32'(cyc - e.acc), 32'd2);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_fp    = out_fp;
            prev_bad   = out_bad_enc;
        end
    end

    // Present one operand (caller is just after a rising edge) and wait for its accept
    task automatic send(input logic s, input logic [8:0] e, input logic [23:0] g,
                        input logic [31:0] fp, input logic bad);
        int t = 0;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_sig   = g;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            sbq.push_back('{fp, bad, cyc, lat_chk});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() > 0) check("drain_timeout", 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic        st_sign [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [8:0]  st_exp  [6] = '{9'h100, 9'd120, 9'd107, 9'h180, 9'h050, 9'h1C0};
    logic [23:0] st_sig  [6] = '{24'hC00000, 24'hF00000, 24'h800000, 24'h000000, 24'h5A5A5A, 24'h800000};
    logic [31:0] st_fp   [6] = '{32'h3FC00000, 32'h80003C00, 32'h00000001, 32'hFF800000, 32'h7FC00000, 32'h7FC00000};
    logic        st_bad  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int  idx;
        int  k;
        bit  saw_not_ready;

        // Reset state
        #3;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_fp", out_fp, 32'd0);
        check("rst_out_bad", {31'b0, out_bad_enc}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Directed conversions, continuous stream, latency checked
        lat_chk = 1'b1;
        send(1'b0, 9'h100, 24'hC00000, 32'h3FC00000, 1'b0);
        send(1'b0, 9'd129, 24'h800000, 32'h00400000, 1'b0);
        send(1'b0, 9'd107, 24'h800000, 32'h00000001, 1'b0);
        send(1'b1, 9'd120, 24'hF00000, 32'h80003C00, 1'b0);
        send(1'b1, 9'h180, 24'h123456, 32'hFF800000, 1'b0);
        send(1'b0, 9'h1C0, 24'h800001, 32'h7F800001, 1'b0);
        send(1'b0, 9'h1C0, 24'h800000, 32'h7FC00000, 1'b0);
        send(1'b1, 9'h1C0, 24'h8ABCDE, 32'hFF8ABCDE, 1'b0);
        send(1'b1, 9'h000, 24'h000000, 32'h80000000, 1'b0);
        send(1'b0, 9'h03F, 24'hFFFFFF, 32'h00000000, 1'b0);
        send(1'b0, 9'h050, 24'h123456, 32'h7FC00000, 1'b1);
        send(1'b0, 9'd106, 24'h800000, 32'h7FC00000, 1'b1);
        send(1'b1, 9'h040, 24'hFFFFFF, 32'h7FC00000, 1'b1);
        send(1'b0, 9'd130, 24'hFFFFFF, 32'h00FFFFFF, 1'b0);
        send(1'b0, 9'h17F, 24'h800000, 32'h7F000000, 1'b0);
        drain();

        // Back-to-back stream of six with a three-cycle consumer stall
        lat_chk = 1'b0;
        saw_not_ready = 1'b0;
        idx = 0;
        k = 0;
        while (idx < 6 && k < 60) begin
            out_ready = !(k >= 2 && k <= 4);
            in_valid  = 1'b1;
            in_sign   = st_sign[idx];
            in_exp    = st_exp[idx];
            in_sig    = st_sig[idx];
            @(negedge clk);
            if (!in_ready) saw_not_ready = 1'b1;
            if (in_ready) begin
                sbq.push_back('{st_fp[idx], st_bad[idx], cyc, 1'b0});
                idx++;
            end
            @(posedge clk);
            #1;
            k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_all_accepted", 32'(idx), 32'd6);
        check("in_ready_fell", {31'b0, saw_not_ready}, 32'd1);
        drain();

        // Reset with both stages occupied
        out_ready = 1'b0;
        send(1'b0, 9'h100, 24'hC00000, 32'h3FC00000, 1'b0);
        send(1'b1, 9'h180, 24'h000000, 32'hFF800000, 1'b0);
        check("pre_rst_full", {31'b0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_fp", out_fp, 32'd0);
        sbq.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle", {31'b0, out_valid}, 32'd0);
        lat_chk = 1'b1;
        send(1'b0, 9'd129, 24'h800000, 32'h00400000, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
